// File: rtl/uart_byte_fifo.sv
// Byte FIFO between UART RX (strobe, no backpressure) and UART TX (valid/ready), first-word-fall-through.
// Define UART_BYTE_FIFO_DROP_CNT_EN to build the saturating counter of writes dropped while full.
module uart_byte_fifo #(
  parameter int DEPTH    = 16,
  parameter int AFULL_TH = 14
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [7:0]               wr_data,
  input  logic                     wr_en,
  output logic [7:0]               out_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     almost_full,
  output logic [15:0]              drop_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] AFULL_C = CW'(AFULL_TH);

  logic [DEPTH-1:0][7:0] mem;
  logic [AW:0]           wr_ptr, rd_ptr;
  logic                  push, pop;

  // Extra pointer MSB separates full from empty; subtraction wraps mod 2*DEPTH.
  assign count       = wr_ptr - rd_ptr;
  assign out_valid   = (count != '0);
  assign full        = (count == DEPTH_C);
  assign almost_full = (count >= AFULL_C);
  assign out_data    = out_valid ? mem[rd_ptr[AW-1:0]] : 8'h00;

  // Full is judged on pre-edge state, so a same-cycle pop cannot rescue a write.
  assign push = wr_en & ~full;
  assign pop  = out_valid & out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Storage is not reset; out_data masking hides stale entries.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= wr_data;
  end

`ifdef UART_BYTE_FIFO_DROP_CNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      drop_cnt <= 16'h0000;
    else if (wr_en && full && drop_cnt != 16'hFFFF)
      drop_cnt <= drop_cnt + 16'h0001;
  end
`else
  assign drop_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_uart_byte_fifo.sv
// Directed self-checking bench for uart_byte_fifo (DEPTH=16, AFULL_TH=14).
module tb_uart_byte_fifo;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  wr_data;
  logic        wr_en;
  logic [7:0]  out_data;
  logic        out_valid;
  logic        out_ready;
  logic [4:0]  count;
  logic        full;
  logic        almost_full;
  logic [15:0] drop_cnt;

  int errors = 0;
  int checks = 0;

`ifdef UART_BYTE_FIFO_DROP_CNT_EN
  localparam int DROP_EN = 1;
`else
  localparam int DROP_EN = 0;
`endif

  uart_byte_fifo #(.DEPTH(16), .AFULL_TH(14)) dut (
    .clk(clk), .rst(rst), .wr_data(wr_data), .wr_en(wr_en),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .count(count), .full(full), .almost_full(almost_full), .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [7:0] d);
    wr_en = 1'b1; wr_data = d;
    tick();
    wr_en = 1'b0;
  endtask

  initial begin
    rst = 1'b1; wr_en = 1'b0; wr_data = 8'h00; out_ready = 1'b0;
    #2;
    check("rst_count", count, 0);
    check("rst_valid", out_valid, 0);
    check("rst_data", out_data, 8'h00);
    check("rst_full", full, 0);
    check("rst_afull", almost_full, 0);
    check("rst_drop", drop_cnt, 0);
    tick();
    rst = 1'b0;
    tick();

    // Three writes, then in-order pops
    wr(8'h41);
    check("t1_lat_valid", out_valid, 1);
    check("t1_lat_data", out_data, 8'h41);
    wr(8'h42);
    wr(8'h43);
    check("t1_count3", count, 3);
    check("t1_head", out_data, 8'h41);
    out_ready = 1'b1;
    check("t1_pop0", out_data, 8'h41); tick();
    check("t1_pop1", out_data, 8'h42); tick();
    check("t1_pop2", out_data, 8'h43); tick();
    out_ready = 1'b0;
    check("t1_count0", count, 0);
    check("t1_empty_data", out_data, 8'h00);
    check("t1_empty_valid", out_valid, 0);

    // 18 writes into a 16-deep FIFO
    for (int i = 0; i < 18; i++) begin
      wr(8'(i));
      check("t2_count", count, (i + 1 > 16) ? 16 : i + 1);
      check("t2_afull", almost_full, (i + 1 >= 14) ? 1 : 0);
      check("t2_full", full, (i + 1 >= 16) ? 1 : 0);
    end
    check("t2_drop", drop_cnt, DROP_EN ? 2 : 0);
    out_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      check("t2_drain", out_data, 32'(i));
      tick();
    end
    out_ready = 1'b0;
    check("t2_empty", out_valid, 0);

    // Full + write + pop in the same cycle: write dropped, pop taken
    for (int i = 0; i < 16; i++) wr(8'h80 + 8'(i));
    check("t3_full", full, 1);
    wr_en = 1'b1; wr_data = 8'hAA; out_ready = 1'b1;
    tick();
    wr_en = 1'b0; out_ready = 1'b0;
    check("t3_count15", count, 15);
    check("t3_drop", drop_cnt, DROP_EN ? 3 : 0);
    out_ready = 1'b1;
    for (int i = 1; i < 16; i++) begin
      check("t3_drain", out_data, 32'(8'h80 + i));
      tick();
    end
    out_ready = 1'b0;
    check("t3_empty", out_valid, 0);

    // Steady state at count=5 through pointer wrap
    for (int i = 0; i < 5; i++) wr(8'h10 + 8'(i));
    out_ready = 1'b1;
    for (int i = 0; i < 40; i++) begin
      wr_en = 1'b1; wr_data = 8'h15 + 8'(i);
      check("t4_head", out_data, 32'(8'h10 + i));
      tick();
      check("t4_count", count, 5);
    end
    wr_en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      check("t4_tail", out_data, 32'(8'h38 + i));
      tick();
    end
    out_ready = 1'b0;
    check("t4_empty", out_valid, 0);
    check("t4_drop", drop_cnt, DROP_EN ? 3 : 0);

    // Asynchronous reset with 7 bytes stored
    for (int i = 0; i < 7; i++) wr(8'h60 + 8'(i));
    check("t5_count7", count, 7);
    #2 rst = 1'b1;
    #1;
    check("t5_async_valid", out_valid, 0);
    check("t5_async_count", count, 0);
    check("t5_async_full", full, 0);
    check("t5_async_data", out_data, 8'h00);
    check("t5_async_drop", drop_cnt, 0);
    tick();
    rst = 1'b0;
    wr(8'h5A);
    check("t5_post_data", out_data, 8'h5A);
    check("t5_post_count", count, 1);

`ifdef UART_BYTE_FIFO_DROP_CNT_EN
    // Saturation of the drop counter
    for (int i = 0; i < 15; i++) wr(8'h00);
    check("t6_full", full, 1);
    wr_en = 1'b1;
    for (int i = 0; i < 70000; i++) tick();
    check("t6_sat", drop_cnt, 16'hFFFF);
    tick(); tick();
    wr_en = 1'b0;
    check("t6_hold", drop_cnt, 16'hFFFF);
    check("t6_count", count, 16);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/uart_byte_fifo.md
# uart_byte_fifo

Byte FIFO sitting between the UART receiver and the UART transmitter. It absorbs single-cycle write strobes from the receive side, which has no backpressure, and presents the stored bytes to the transmit side over a valid/ready handshake. A byte is never lost while space remains. Writes arriving when the FIFO is full are discarded, and counted when the drop counter is compiled in.

## Interface
Parameters:
- DEPTH, 16, number of byte entries; power of two, ≥ 4
- AFULL_TH, 14, occupancy at or above which almost_full asserts; range 1..DEPTH

Ports:
- clk  in  1  system clock; all state changes on the rising edge
- rst  in  1  reset; asynchronous, active-high
- wr_data  in  8  byte to store; sampled when wr_en=1
- wr_en  in  1  single-cycle write strobe (receiver data-valid pulse); no backpressure
- out_data  out  8  head byte; 8'h00 whenever out_valid=0
- out_valid  out  1  FIFO non-empty
- out_ready  in  1  consumer accepts head byte (transmitter ready)
- count  out  $clog2(DEPTH)+1  current occupancy, 0..DEPTH
- full  out  1  count == DEPTH
- almost_full  out  1  count ≥ AFULL_TH
- drop_cnt  out  16  saturating count of discarded writes

## Operation
- Storage: DEPTH×8 register array. The write pointer and read pointer are each $clog2(DEPTH)+1 bits. The MSB distinguishes full from empty.
- Pointers wrap naturally modulo 2·DEPTH. The array index is the pointer's low bits.
- Write: if wr_en=1 and full=0 at the edge, store wr_data at wr_ptr and increment wr_ptr.
- Drop: if wr_en=1 and full=1 at the edge, the write is discarded. This applies even if a read occurs in the same cycle; full is judged on pre-edge state. drop_cnt increments by 1 (see Configuration).
- Read: a pop occurs when out_valid=1 and out_ready=1 at the edge; rd_ptr increments. out_ready while out_valid=0 has no effect.
- Simultaneous write and pop, not full: both occur and count is unchanged.
- Simultaneous write and pop, empty: impossible, since out_valid=0.
- First-word-fall-through: out_data = array[rd_ptr] combinationally when out_valid=1, otherwise 8'h00.
- count = wr_ptr − rd_ptr, modulo 2·DEPTH. out_valid = (count≠0). full and almost_full are derived from count.
- No state machine beyond the pointers; no other internal modes.

## Timing
- Reset (asynchronous assert, synchronous-safe deassert externally): wr_ptr=0, rd_ptr=0, drop_cnt=0.
- Output values during reset: count=0, out_valid=0, out_data=8'h00, full=0, almost_full=0 (0 as long as AFULL_TH ≥ 1).
- Array contents are not reset. They are never visible because of the out_data masking.
- Reset mid-operation: all stored bytes are discarded immediately. The handshake is held idle (out_valid=0) from reset assertion onward.
- Write-to-read latency: a byte written at edge N into an empty FIFO gives out_valid=1 and out_data=byte in the cycle after edge N.
- Pop latency: after a pop at edge N, the next byte (or out_valid=0) is visible in the cycle after edge N. Back-to-back pops at one per cycle are supported.
- full, almost_full and count update in the cycle after the causing edge. There are no combinational paths from wr_en to any output.
- The only combinational path from an input to an output: out_ready has none. out_data depends only on registered state.

## Configuration
- Macro: UART_BYTE_FIFO_DROP_CNT_EN.
- Defined: drop_cnt is a 16-bit register that increments on each dropped write and saturates at 16'hFFFF; reset to 0.
- Undefined: drop_cnt is constant 16'h0000 and no counter logic is generated. Drop behaviour is otherwise identical.

## Test plan
- Reset, then write 8'h41, 8'h42, 8'h43 on consecutive cycles with out_ready=0 -> count=3, out_valid=1, out_data=8'h41. Then out_ready=1 for 3 cycles -> pops 41, 42, 43 in order; count=0; out_data=8'h00.
- Write 18 bytes 8'h00..8'h11 with out_ready=0, DEPTH=16 -> full=1 after the 16th write; almost_full=1 from count=14. With the macro defined, drop_cnt=2; without it, drop_cnt=0. Drain yields 8'h00..8'h0F exactly.
- Fill to full, then wr_en=1 with wr_data=8'hAA in the same cycle as a pop -> pop occurs, 8'hAA is dropped, count=15, drop_cnt increments (macro defined).
- Hold count=5 with continuous wr_en and out_ready=1 for 40 cycles (pointer wrap) -> count stays 5; output order matches input order; no drops.
- With 7 bytes stored, assert rst mid-cycle -> out_valid, count and full go to 0 before the next edge. After release, one write of 8'h5A -> out_data=8'h5A the following cycle.
- With the macro defined, force 70000 drops -> drop_cnt=16'hFFFF and holds.
